// File: rtl/kbest_update_unit.sv
// K-best result memory read-modify-write front end: sorted insertion of candidates plus clear sweep.
// Optional build macro KBEST_DEDUP_EN discards candidates whose idx already sits in the list.
module kbest_update_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_WIDTH  = 9,
   parameter int unsigned DIST_WIDTH = DATA_WIDTH - IDX_WIDTH,
   parameter int unsigned K          = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_init,
   output logic                      o_init_done,
   output logic                      o_busy,
   input  logic                      i_in_valid,
   output logic                      o_in_ready,
   input  logic [7:0]                i_in_addr,
   input  logic [DIST_WIDTH-1:0]     i_in_dist,
   input  logic [IDX_WIDTH-1:0]      i_in_idx,
   output logic                      o_mem_csb0,
   output logic                      o_mem_web0,
   output logic [7:0]                o_mem_addr0,
   output logic [K*DATA_WIDTH-1:0]   o_mem_wdata0,
   input  logic [K*DATA_WIDTH-1:0]   i_mem_rdata0
);

   localparam int unsigned       PW = $clog2(K + 1);
   localparam int unsigned       WW = K * DATA_WIDTH;
   localparam logic [PW-1:0]     KP = PW'(K);

   typedef enum logic [2:0] {StIdle, StInit, StRead, StMerge, StWrite} state_e;

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic [7:0]              r_cnt;
   logic [7:0]              r_mem_addr0;
   logic [WW-1:0]           r_mem_wdata0;
   logic [DIST_WIDTH-1:0]   r_dist;
   logic [IDX_WIDTH-1:0]    r_idx;
   logic                    r_init_done;

   logic [DATA_WIDTH-1:0]   w_cand;
   logic [WW-1:0]           w_shift;
   logic [WW-1:0]           w_merged;
   logic [PW-1:0]           w_pos;
   logic                    w_dup;
   logic                    w_discard;

   assign o_mem_addr0  = r_mem_addr0;
   assign o_mem_wdata0 = r_mem_wdata0;
   assign o_init_done  = r_init_done;
   assign o_busy       = (r_state != StIdle);
   assign o_in_ready   = (r_state == StIdle) && !i_init;

   assign w_cand  = {r_dist, r_idx};
   // Old list moved down one rank; rank 0 filler is never selected.
   assign w_shift = {i_mem_rdata0[WW-DATA_WIDTH-1:0], {DATA_WIDTH{1'b1}}};

   always_comb begin
      w_pos    = '0;
      w_dup    = 1'b0;
      w_merged = '0;
      for (int r = 0; r < K; r++) begin
         if (i_mem_rdata0[r*DATA_WIDTH + IDX_WIDTH +: DIST_WIDTH] <= r_dist) begin
            w_pos = w_pos + 1'b1;
         end
`ifdef KBEST_DEDUP_EN
         if ((i_mem_rdata0[r*DATA_WIDTH +: DATA_WIDTH] != {DATA_WIDTH{1'b1}}) &&
             (i_mem_rdata0[r*DATA_WIDTH +: IDX_WIDTH] == r_idx)) begin
            w_dup = 1'b1;
         end
`endif
      end
      for (int r = 0; r < K; r++) begin
         if (PW'(r) < w_pos) begin
            w_merged[r*DATA_WIDTH +: DATA_WIDTH] = i_mem_rdata0[r*DATA_WIDTH +: DATA_WIDTH];
         end else if (PW'(r) == w_pos) begin
            w_merged[r*DATA_WIDTH +: DATA_WIDTH] = w_cand;
         end else begin
            w_merged[r*DATA_WIDTH +: DATA_WIDTH] = w_shift[r*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_discard = (w_pos == KP) || w_dup;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_mem_csb0  = 1'b1;
      o_mem_web0  = 1'b1;
      unique case (r_state)
         StIdle: begin
            if (i_init) begin
               w_state_nxt = StInit;
            end else if (i_in_valid) begin
               w_state_nxt = StRead;
            end
         end
         StInit: begin
            o_mem_csb0 = 1'b0;
            o_mem_web0 = 1'b0;
            if (r_cnt == 8'hFF) begin
               w_state_nxt = StIdle;
            end
         end
         StRead: begin
            o_mem_csb0  = 1'b0;
            w_state_nxt = StMerge;
         end
         StMerge: begin
            w_state_nxt = w_discard ? StIdle : StWrite;
         end
         StWrite: begin
            o_mem_csb0  = 1'b0;
            o_mem_web0  = 1'b0;
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt        <= '0;
         r_mem_addr0  <= '0;
         r_mem_wdata0 <= '0;
         r_dist       <= '0;
         r_idx        <= '0;
         r_init_done  <= 1'b0;
      end else begin
         r_init_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (i_init) begin
                  r_cnt        <= '0;
                  r_mem_addr0  <= '0;
                  r_mem_wdata0 <= '1;
               end else if (i_in_valid) begin
                  r_mem_addr0 <= i_in_addr;
                  r_dist      <= i_in_dist;
                  r_idx       <= i_in_idx;
               end
            end
            StInit: begin
               // Address 255 stays on the bus after the sweep ends.
               if (r_cnt == 8'hFF) begin
                  r_init_done <= 1'b1;
               end else begin
                  r_cnt       <= r_cnt + 8'd1;
                  r_mem_addr0 <= r_cnt + 8'd1;
               end
            end
            StMerge: begin
               if (!w_discard) begin
                  r_mem_wdata0 <= w_merged;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kbest_update_unit.sv
// Self-checking bench for kbest_update_unit: SRAM model, vector table, timing sequences and
// randomized candidates checked against a sorted-list reference model.
module tb_kbest_update_unit;

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 9;
   localparam int unsigned SW = 23;
   localparam int unsigned KK = 4;
   localparam int unsigned WW = KK * DW;
   localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;
   localparam int          DMAX  = 32'h7F_FFFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          init = 1'b0;
   logic          init_done;
   logic          busy;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    in_addr = '0;
   logic [SW-1:0] in_dist = '0;
   logic [IW-1:0] in_idx = '0;
   logic          csb0;
   logic          web0;
   logic [7:0]    addr0;
   logic [WW-1:0] wdata0;
   logic [WW-1:0] rdata0;

   always #5 clk = ~clk;

   kbest_update_unit #(
      .DATA_WIDTH(DW),
      .IDX_WIDTH (IW),
      .DIST_WIDTH(SW),
      .K         (KK)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_init      (init),
      .o_init_done (init_done),
      .o_busy      (busy),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_addr   (in_addr),
      .i_in_dist   (in_dist),
      .i_in_idx    (in_idx),
      .o_mem_csb0  (csb0),
      .o_mem_web0  (web0),
      .o_mem_addr0 (addr0),
      .o_mem_wdata0(wdata0),
      .i_mem_rdata0(rdata0)
   );

   // 1rw SRAM port 0 model, read data one cycle after the read edge.
   logic [WW-1:0] sram [256];
   int            wr_count = 0;
   int            cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (csb0 === 1'b0) begin
         if (web0 === 1'b0) begin
            sram[addr0] <= wdata0;
            wr_count    <= wr_count + 1;
         end else begin
            rdata0 <= sram[addr0];
         end
      end
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] ent(input int d, input int i);
      logic [SW-1:0] dd;
      logic [IW-1:0] ii;
      dd = SW'(d);
      ii = IW'(i);
      return {dd, ii};
   endfunction

   function automatic logic [WW-1:0] lst(input logic [31:0] e0, input logic [31:0] e1,
                                         input logic [31:0] e2, input logic [31:0] e3);
      return {e3, e2, e1, e0};
   endfunction

   // Reference: list as a queue, insert after every entry with dist <= candidate, keep K.
   function automatic logic [WW-1:0] ref_ins(input logic [WW-1:0] cur, input logic [SW-1:0] d,
                                             input logic [IW-1:0] ix, output bit wr);
      logic [31:0] q[$];
      logic [31:0] e;
      int          pos;
      for (int r = 0; r < KK; r++) q.push_back(cur[r*DW +: DW]);
      wr = 1'b1;
`ifdef KBEST_DEDUP_EN
      for (int r = 0; r < KK; r++) begin
         e = q[r];
         if (e != EMPTY && e[IW-1:0] == ix) wr = 1'b0;
      end
`endif
      pos = 0;
      for (int r = 0; r < KK; r++) begin
         e = q[r];
         if (e[DW-1:IW] <= d) pos = r + 1;
      end
      if (pos >= KK) wr = 1'b0;
      if (!wr) return cur;
      q.insert(pos, {d, ix});
      return {q[3], q[2], q[1], q[0]};
   endfunction

   task automatic wait_idle();
      int t;
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) begin
         n_total++;
         $display("FAIL idle_timeout: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic send(input logic [7:0] a, input int d, input int ix, output int t_acc);
      wait_idle();
      in_valid = 1'b1;
      in_addr  = a;
      in_dist  = SW'(d);
      in_idx   = IW'(ix);
      @(negedge clk);
      t_acc    = cyc;
      in_valid = 1'b0;
   endtask

   task automatic run_cand(input string name, input logic [7:0] a, input int d, input int ix,
                           input logic [WW-1:0] exp, input bit exp_wr);
      int w0;
      int ta;
      w0 = wr_count;
      send(a, d, ix, ta);
      wait_idle();
      chk({name, "_list"}, sram[a], exp);
      chk({name, "_wr"}, WW'(wr_count - w0), WW'(exp_wr));
   endtask

   typedef struct {
      logic [7:0]    a;
      int            d;
      int            ix;
      logic [WW-1:0] exp;
      bit            wr;
   } vec_t;

   vec_t          tbl [14];
   logic [WW-1:0] refm [256];

   initial begin
      int            bad;
      int            w0;
      int            t1;
      int            t2;
      logic [7:0]    ra;
      int            rd;
      int            rx;
      bit            ew;
      logic [WW-1:0] rexp;

      tbl[0]  = '{8'd5,  40,   1,   lst(ent(40, 1), EMPTY, EMPTY, EMPTY), 1'b1};
      tbl[1]  = '{8'd5,  10,   2,   lst(ent(10, 2), ent(40, 1), EMPTY, EMPTY), 1'b1};
      tbl[2]  = '{8'd5,  25,   3,   lst(ent(10, 2), ent(25, 3), ent(40, 1), EMPTY), 1'b1};
      tbl[3]  = '{8'd7,  20,   4,   lst(ent(20, 4), EMPTY, EMPTY, EMPTY), 1'b1};
      tbl[4]  = '{8'd7,  12,   3,   lst(ent(12, 3), ent(20, 4), EMPTY, EMPTY), 1'b1};
      tbl[5]  = '{8'd7,  8,    2,   lst(ent(8, 2), ent(12, 3), ent(20, 4), EMPTY), 1'b1};
      tbl[6]  = '{8'd7,  5,    1,   lst(ent(5, 1), ent(8, 2), ent(12, 3), ent(20, 4)), 1'b1};
      tbl[7]  = '{8'd7,  20,   7,   lst(ent(5, 1), ent(8, 2), ent(12, 3), ent(20, 4)), 1'b0};
      tbl[8]  = '{8'd7,  8,    9,   lst(ent(5, 1), ent(8, 2), ent(8, 9), ent(12, 3)), 1'b1};
      tbl[9]  = '{8'd7,  0,    6,   lst(ent(0, 6), ent(5, 1), ent(8, 2), ent(8, 9)), 1'b1};
      tbl[10] = '{8'd9,  10,   2,   lst(ent(10, 2), EMPTY, EMPTY, EMPTY), 1'b1};
`ifdef KBEST_DEDUP_EN
      tbl[11] = '{8'd9,  1,    2,   lst(ent(10, 2), EMPTY, EMPTY, EMPTY), 1'b0};
`else
      tbl[11] = '{8'd9,  1,    2,   lst(ent(1, 2), ent(10, 2), EMPTY, EMPTY), 1'b1};
`endif
      tbl[12] = '{8'd10, 3,    511, lst(ent(3, 511), EMPTY, EMPTY, EMPTY), 1'b1};
      tbl[13] = '{8'd11, DMAX, 0,   lst(EMPTY, EMPTY, EMPTY, EMPTY), 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_csb0", csb0, 1);
      chk("rst_web0", web0, 1);
      chk("rst_addr0", addr0, 0);
      chk("rst_wdata0", wdata0, 0);

      // Clear sweep; init wins over a simultaneous candidate
      w0       = wr_count;
      init     = 1'b1;
      in_valid = 1'b1;
      in_addr  = 8'd77;
      #1;
      chk("ready_during_init", in_ready, 0);
      @(negedge clk);
      init     = 1'b0;
      in_valid = 1'b0;
      bad      = 0;
      for (int n = 1; n <= 256; n++) begin
         if (!(csb0 === 1'b0 && web0 === 1'b0 && addr0 === 8'(n - 1) && wdata0 === '1 &&
               init_done === 1'b0 && busy === 1'b1)) bad++;
         @(negedge clk);
      end
      chk("sweep_bad_cycles", WW'(bad), 0);
      chk("sweep_write_count", WW'(wr_count - w0), 256);
      chk("init_done_pulse", init_done, 1);
      chk("after_sweep_busy", busy, 0);
      chk("after_sweep_ready", in_ready, 1);
      chk("after_sweep_csb0", csb0, 1);
      chk("after_sweep_addr0", addr0, 8'd255);
      @(negedge clk);
      chk("init_done_one_cycle", init_done, 0);
      for (int i = 0; i < 256; i++) refm[i] = '1;

      for (int i = 0; i < 14; i++) begin
         run_cand($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].ix, tbl[i].exp, tbl[i].wr);
      end

      // Back-to-back to addr 3 with cycle-level timing
      w0 = wr_count;
      send(8'd3, 30, 5, t1);
      chk("read_ctl", {csb0, web0}, 2'b01);
      chk("read_addr", addr0, 8'd3);
      @(negedge clk);
      chk("merge_ctl", {csb0, web0}, 2'b11);
      chk("merge_busy", busy, 1);
      @(negedge clk);
      chk("write_ctl", {csb0, web0}, 2'b00);
      chk("write_data", wdata0, lst(ent(30, 5), EMPTY, EMPTY, EMPTY));
      @(negedge clk);
      chk("ready_after_write", in_ready, 1);
      send(8'd3, 4, 6, t2);
      chk("b2b_spacing", WW'(t2 - t1), 4);
      wait_idle();
      chk("b2b_list", sram[3], lst(ent(4, 6), ent(30, 5), EMPTY, EMPTY));
      chk("b2b_writes", WW'(wr_count - w0), 2);

      // Discarded candidates free the unit after 3 cycles
      w0 = wr_count;
      send(8'd11, DMAX, 1, t1);
      send(8'd11, DMAX, 2, t2);
      wait_idle();
      chk("discard_spacing", WW'(t2 - t1), 3);
      chk("discard_writes", WW'(wr_count - w0), 0);

      // Random candidates on a few fresh addresses
      for (int n = 0; n < 60; n++) begin
         ra   = 8'(16 + $urandom_range(0, 5));
         rd   = ($urandom_range(0, 11) == 0) ? DMAX : int'($urandom_range(0, 40));
         rx   = int'($urandom_range(0, 5));
         rexp = ref_ins(refm[ra], SW'(rd), IW'(rx), ew);
         refm[ra] = rexp;
         run_cand($sformatf("rand%0d", n), ra, rd, rx, rexp, ew);
      end

      // Reset during MERGE abandons the write
      w0 = wr_count;
      send(8'd40, 7, 1, t1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_ctl", {csb0, web0}, 2'b11);
      chk("mrst_addr0", addr0, 0);
      chk("mrst_wdata0", wdata0, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_init_done", init_done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_ready", in_ready, 1);
      repeat (4) @(negedge clk);
      chk("mrst_no_write", WW'(wr_count - w0), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
